// File: rtl/sram_like_if.sv
// SRAM-like bus: address phase (request/address_ready) followed by data phase (data_ready).
// The master modport drives the request side; the slave modport answers it.
interface sram_like_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  request;
   logic                  write;
   logic [1:0]            size;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [3:0]            write_strobe;
   logic                  address_ready;
   logic                  data_ready;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output request, write, size, address, write_data, write_strobe,
      input  address_ready, data_ready, read_data
   );

   modport slave (
      input  request, write, size, address, write_data, write_strobe,
      output address_ready, data_ready, read_data
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the fetch master and the data master.
// One outstanding transaction; data has priority, bounded by a starvation streak counter.
module sram_like_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32
) (
   input  logic       clock,
   input  logic       reset,
   sram_like_if.slave  inst,
   sram_like_if.slave  data,
   sram_like_if.master mem
);
   localparam int unsigned STREAK_WIDTH = 4;
   localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                  state_q, state_d;
   logic                    owner_q, owner_d;   // 1 = data master owns the port
   logic [STREAK_WIDTH-1:0] streak_q, streak_d;

   logic                    sel_data_c;
   logic                    mem_request_c;
   logic                    handshake_c;
   logic                    in_data_c;
   logic [ADDR_WIDTH-1:0]   fwd_address_c;
   logic [DATA_WIDTH-1:0]   fwd_write_data_c;

   // State, owner and streak registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   // Arbitration, next state and streak update
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      streak_d      = streak_q;
      sel_data_c    = owner_q;
      mem_request_c = 1'b0;
      case (state_q)
         IDLE: begin
            sel_data_c    = data.request && (!inst.request || (streak_q < STREAK_MAX));
            mem_request_c = data.request || inst.request;
            if (mem_request_c) begin
               owner_d = sel_data_c;
               state_d = mem.address_ready ? DATA : ADDR;
            end
         end
         ADDR: begin
            // A dropped owner request is a flush: abandon without a handshake.
            mem_request_c = owner_q ? data.request : inst.request;
            if (!mem_request_c)
               state_d = IDLE;
            else if (mem.address_ready)
               state_d = DATA;
         end
         DATA: begin
            if (mem.data_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      handshake_c = mem_request_c && mem.address_ready;
      if (handshake_c) begin
         if (sel_data_c && inst.request)
            streak_d = (streak_q < STREAK_MAX) ? streak_q + STREAK_WIDTH'(1) : STREAK_MAX;
         else
            streak_d = '0;
      end
   end

   assign in_data_c        = (state_q == DATA);
   assign fwd_address_c    = sel_data_c ? data.address    : inst.address;
   assign fwd_write_data_c = sel_data_c ? data.write_data : inst.write_data;

   // Forward the selected master's fields to the slave
   assign mem.request      = mem_request_c;
   assign mem.write        = sel_data_c ? data.write        : inst.write;
   assign mem.size         = sel_data_c ? data.size         : inst.size;
   assign mem.write_strobe = sel_data_c ? data.write_strobe : inst.write_strobe;
   assign mem.address      = fwd_address_c;
   assign mem.write_data   = fwd_write_data_c;

   // Readies reach only the owner, and only in the phase they belong to
   assign inst.address_ready = handshake_c && !sel_data_c;
   assign data.address_ready = handshake_c &&  sel_data_c;
   assign inst.data_ready    = in_data_c && mem.data_ready && !owner_q;
   assign data.data_ready    = in_data_c && mem.data_ready &&  owner_q;
   assign inst.read_data     = mem.read_data;
   assign data.read_data     = mem.read_data;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a transaction-level reference model.
module tb_sram_like_arbiter;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned MAXS = 4;

   logic clock;
   logic reset;

   sram_like_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) inst_bus ();
   sram_like_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) data_bus ();
   sram_like_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

   sram_like_arbiter #(.MAX_DATA_STREAK(MAXS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock (clock),
      .reset (reset),
      .inst  (inst_bus),
      .data  (data_bus),
      .mem   (mem_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // master 0 = fetch, master 1 = data
   logic          m_req   [2];
   logic          m_write [2];
   logic [1:0]    m_size  [2];
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wdata [2];
   logic [3:0]    m_strb  [2];
   int            ms      [2];   // 0 = gap, 1 = requesting, 2 = awaiting data
   int            gap     [2];
   logic          s_ar, s_dr;
   logic [DW-1:0] s_rdata;

   assign inst_bus.request      = m_req[0];
   assign inst_bus.write        = m_write[0];
   assign inst_bus.size         = m_size[0];
   assign inst_bus.address      = m_addr[0];
   assign inst_bus.write_data   = m_wdata[0];
   assign inst_bus.write_strobe = m_strb[0];
   assign data_bus.request      = m_req[1];
   assign data_bus.write        = m_write[1];
   assign data_bus.size         = m_size[1];
   assign data_bus.address      = m_addr[1];
   assign data_bus.write_data   = m_wdata[1];
   assign data_bus.write_strobe = m_strb[1];
   assign mem_bus.address_ready = s_ar;
   assign mem_bus.data_ready    = s_dr;
   assign mem_bus.read_data     = s_rdata;

   // reference model: bus occupancy, owner, streak
   int busy;     // 0 free, 1 address pending, 2 awaiting data
   int who;
   int streak;
   int checks, errors;
   int gap_max, ar_pct, dr_pct, flush_pct;
   logic [9:0] glog;
   int gcount;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy = 0; who = 0; streak = 0;
      for (int m = 0; m < 2; m++) begin
         ms[m] = 0; gap[m] = 0; m_req[m] = 1'b0;
      end
   endtask

   task automatic new_req(input int m);
      m_req[m]   = 1'b1;
      m_addr[m]  = AW'($urandom);
      m_write[m] = (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_size[m]  = 2'($urandom_range(0, 2));
      m_wdata[m] = DW'($urandom);
      m_strb[m]  = 4'($urandom_range(0, 15));
      ms[m]      = 1;
   endtask

   task automatic rand_drive();
      for (int m = 0; m < 2; m++) begin
         case (ms[m])
            0: if (gap[m] == 0) new_req(m);
               else begin gap[m]--; m_req[m] = 1'b0; end
            1: if (flush_pct > 0 && $urandom_range(0, 99) < flush_pct) begin
                  m_req[m] = 1'b0; ms[m] = 0; gap[m] = $urandom_range(0, gap_max);
               end
            default: m_req[m] = 1'b0;
         endcase
      end
      s_ar    = ($urandom_range(0, 99) < ar_pct);
      s_dr    = ($urandom_range(0, 99) < dr_pct);
      s_rdata = DW'($urandom);
   endtask

   // Check one cycle's outputs against the model, then advance the model across the edge.
   task automatic step();
      int   grant, sel;
      logic exp_req, hs, dr0, dr1;
      #2;
      grant = -1;
      if (busy == 0) begin
         if (m_req[1] && (!m_req[0] || streak < int'(MAXS))) grant = 1;
         else if (m_req[0]) grant = 0;
         sel = grant; exp_req = (grant >= 0);
      end else begin
         sel = who; exp_req = (busy == 1) ? m_req[who] : 1'b0;
      end
      hs  = exp_req && s_ar;
      dr0 = (busy == 2) && s_dr && (who == 0);
      dr1 = (busy == 2) && s_dr && (who == 1);
      check("mem_request", 128'(mem_bus.request), 128'(exp_req));
      if (exp_req)
         check("mem_fields",
               128'({mem_bus.write, mem_bus.size, mem_bus.address, mem_bus.write_data, mem_bus.write_strobe}),
               128'({m_write[sel], m_size[sel], m_addr[sel], m_wdata[sel], m_strb[sel]}));
      check("inst_address_ready", 128'(inst_bus.address_ready), 128'(hs && sel == 0));
      check("data_address_ready", 128'(data_bus.address_ready), 128'(hs && sel == 1));
      check("inst_data_ready", 128'(inst_bus.data_ready), 128'(dr0));
      check("data_data_ready", 128'(data_bus.data_ready), 128'(dr1));
      check("inst_read_data", 128'(inst_bus.read_data), 128'(s_rdata));
      check("data_read_data", 128'(data_bus.read_data), 128'(s_rdata));

      if (hs) begin
         if (sel == 1 && m_req[0]) streak = (streak < int'(MAXS)) ? streak + 1 : int'(MAXS);
         else streak = 0;
         glog = {glog[8:0], (sel == 1)};
         gcount++;
         ms[sel] = 2;
      end
      case (busy)
         0: if (grant >= 0) begin who = grant; busy = s_ar ? 2 : 1; end
         1: if (!m_req[who]) busy = 0;
            else if (s_ar) busy = 2;
         default: if (s_dr) begin
               busy = 0; ms[who] = 0; gap[who] = $urandom_range(0, gap_max);
            end
      endcase
      @(negedge clock);
   endtask

   initial begin
      checks = 0; errors = 0; gcount = 0; glog = '0;
      gap_max = 0; ar_pct = 100; dr_pct = 100; flush_pct = 0;
      for (int m = 0; m < 2; m++) begin
         m_write[m] = 1'b0; m_size[m] = 2'd0; m_addr[m] = '0; m_wdata[m] = '0; m_strb[m] = '0;
      end
      model_reset();
      s_ar = 1'b1; s_dr = 1'b1; s_rdata = '0;
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("reset_mem_request", 128'(mem_bus.request), 128'(0));
      check("reset_readies", 128'({inst_bus.address_ready, inst_bus.data_ready,
                                   data_bus.address_ready, data_bus.data_ready}), 128'(0));
      reset = 1'b1;
      s_ar = 1'b0; s_dr = 1'b0;
      step();

      // single fetch: address accepted at once, data two cycles later
      m_req[0] = 1'b1; m_addr[0] = 32'hbfc00000; m_size[0] = 2'd2; m_write[0] = 1'b0;
      m_wdata[0] = '0; m_strb[0] = 4'hf; ms[0] = 1;
      s_ar = 1'b1; s_dr = 1'b0;
      #1 check("t1_mem_address", 128'(mem_bus.address), 128'(32'hbfc00000));
      step();
      m_req[0] = 1'b0; s_ar = 1'b0; s_dr = 1'b0;
      step();
      s_dr = 1'b1; s_rdata = 32'h3c1d0001;
      #1 check("t1_rdata", 128'(inst_bus.read_data), 128'(32'h3c1d0001));
      check("t1_data_ready", 128'(inst_bus.data_ready), 128'(1));
      step();

      // starvation bound with both masters always requesting
      ms[0] = 0; ms[1] = 0; gap[0] = 0; gap[1] = 0;
      gap_max = 0; ar_pct = 100; dr_pct = 100; flush_pct = 0;
      gcount = 0; glog = '0;
      for (int i = 0; i < 200 && gcount < 10; i++) begin
         rand_drive();
         step();
      end
      check("t3_grant_order", 128'(glog), 128'(10'b1111011110));

      // random traffic with stalls, flushes and stray readies
      gap_max = 3; ar_pct = 60; dr_pct = 40; flush_pct = 5;
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         step();
      end

      // drain to idle, then reset in the middle of a data phase
      m_req[0] = 1'b0; m_req[1] = 1'b0; s_ar = 1'b0; s_dr = 1'b1;
      for (int i = 0; i < 20 && busy != 0; i++) step();
      check("t6_drained", 128'(busy), 128'(0));
      ms[0] = 1; m_req[0] = 1'b1; m_addr[0] = 32'hbfc00010; s_ar = 1'b1; s_dr = 1'b0;
      step();
      m_req[0] = 1'b0; s_ar = 1'b0; s_dr = 1'b1;
      #1 check("t6_before_reset", 128'(inst_bus.data_ready), 128'(1));
      reset = 1'b0;
      #1 check("t6_async_data_ready", 128'({inst_bus.data_ready, data_bus.data_ready}), 128'(0));
      check("t6_async_mem_request", 128'(mem_bus.request), 128'(0));
      model_reset();
      @(negedge clock);
      reset = 1'b1; s_dr = 1'b1;
      step();
      check("t6_stray_data_ready", 128'({inst_bus.data_ready, data_bus.data_ready}), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
